// File: rtl/papuf_pkg.sv
// Shared types and constants for the XOR arbiter-PUF evaluator.
package papuf_pkg;

  localparam int PAPUF_CW = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FIRE,
    SAMPLE,
    DONE
  } state_t;

  function automatic bit params_ok(input int votes, input int settle);
    return ((votes % 2) == 1) && (settle >= 3);
  endfunction

endpackage

// File: rtl/papuf_ff1.sv
// Behavioural stand-in for the arbiter-PUF hard cell: the arbiter is held
// reset while pulse is low and resolves to a challenge-dependent bit once it rises.
module papuf_ff1
  import papuf_pkg::*;
#(
  parameter logic [PAPUF_CW-1:0] SEED = 16'h0001
) (
  input  logic [PAPUF_CW-1:0] challenge,
  input  logic                pulse,
  output logic                resp
);

  assign resp = pulse & (^(challenge & SEED));

endmodule

// File: rtl/papuf_xor_bit.sv
// One response bit: XN arbiter cells sharing the challenge and pulse,
// XOR-reduced into a single raw bit.
module papuf_xor_bit
  import papuf_pkg::*;
#(
  parameter int XN  = 2,
  parameter int IDX = 0
) (
  input  logic [PAPUF_CW-1:0] challenge,
  input  logic                pulse,
  output logic                raw
);

  logic [XN-1:0] cell_resp;

  for (genvar c = 0; c < XN; c++) begin : g_cell
    papuf_ff1 #(
      .SEED(PAPUF_CW'(32'h9E37 * (IDX * 4 + c + 1)))
    ) u_cell (
      .challenge(challenge),
      .pulse    (pulse),
      .resp     (cell_resp[c])
    );
  end

  assign raw = ^cell_resp;

endmodule

// File: rtl/xpapuf_tmv.sv
// XOR arbiter-PUF evaluator: sequences the cell array through VOTES
// evaluations and majority-votes each response bit, flagging unstable bits.
module xpapuf_tmv
  import papuf_pkg::*;
#(
  parameter int RW     = 16,
  parameter int XN     = 2,
  parameter int VOTES  = 5,
  parameter int SETTLE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [PAPUF_CW-1:0] challenge,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RW-1:0]       response,
  output logic [RW-1:0]       rsp_unstable,
  output logic                busy
);

  localparam int CW = $clog2(VOTES + 1);
  localparam int SW = $clog2(SETTLE + 1);

  if (!params_ok(VOTES, SETTLE)) begin : g_bad_params
    $error("xpapuf_tmv: VOTES must be odd and SETTLE must be at least 3");
  end

  state_t              state_q, state_d;
  logic [SW-1:0]       settle_q;
  logic [CW-1:0]       vote_cnt_q, vote_nxt;
  logic [CW-1:0]       ones_q   [RW];
  logic [CW-1:0]       ones_inc [RW];
  logic [PAPUF_CW-1:0] chal_q;
  logic                pulse;
  logic [RW-1:0]       raw, sync1_q, sync2_q, resp_d, unst_d;

  for (genvar i = 0; i < RW; i++) begin : g_bit
    papuf_xor_bit #(
      .XN (XN),
      .IDX(i)
    ) u_bit (
      .challenge(chal_q),
      .pulse    (pulse),
      .raw      (raw[i])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ARM;
      ARM:     state_d = FIRE;
      FIRE:    if (settle_q == SW'(SETTLE - 1)) state_d = SAMPLE;
      SAMPLE:  state_d = (vote_nxt < CW'(VOTES)) ? ARM : DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Vote tallies including the sample being taken this cycle.
  always_comb begin
    vote_nxt = vote_cnt_q + CW'(1);
    resp_d   = '0;
    unst_d   = '0;
    for (int i = 0; i < RW; i++) begin
      ones_inc[i] = ones_q[i] + CW'(sync2_q[i]);
      resp_d[i]   = ones_inc[i] > CW'(VOTES / 2);
      unst_d[i]   = (ones_inc[i] != '0) && (ones_inc[i] != CW'(VOTES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pulse        <= 1'b0;
      settle_q     <= '0;
      vote_cnt_q   <= '0;
      chal_q       <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      response     <= '0;
      rsp_unstable <= '0;
      for (int i = 0; i < RW; i++) ones_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pulse    <= (state_d == FIRE);
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      settle_q <= (state_q == FIRE) ? settle_q + SW'(1) : '0;
      if (state_q == IDLE && req_valid) begin
        chal_q     <= challenge;
        vote_cnt_q <= '0;
        for (int i = 0; i < RW; i++) ones_q[i] <= '0;
      end
      if (state_q == SAMPLE) begin
        vote_cnt_q <= vote_nxt;
        for (int i = 0; i < RW; i++) ones_q[i] <= ones_inc[i];
        if (state_d == DONE) begin
          response     <= resp_d;
          rsp_unstable <= unst_d;
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q == ARM) || (state_q == FIRE) || (state_q == SAMPLE);

endmodule

// File: tb/tb_xpapuf_tmv.sv
// Bench for xpapuf_tmv: forces cell outputs per evaluation and compares
// against a vote-counting reference model, for the default and an XN=4 build.
module tb_xpapuf_tmv;

  localparam int RW_A = 16, XN_A = 2, V_A = 5, S_A = 3, EVAL_A = S_A + 2;
  localparam int RW_B = 8,  XN_B = 4, V_B = 3, S_B = 4, EVAL_B = S_B + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, busy_a;
  logic [15:0]     challenge_a;
  logic [RW_A-1:0] response_a, rsp_unstable_a;

  logic            req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, busy_b;
  logic [15:0]     challenge_b;
  logic [RW_B-1:0] response_b, rsp_unstable_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] cells_a = '0, cells_b = '0;
  int          stim_gen_a = 0, stim_gen_b = 0;
  logic [31:0] seq_a [15];
  logic [31:0] seq_b [15];

  xpapuf_tmv #(.RW(RW_A), .XN(XN_A), .VOTES(V_A), .SETTLE(S_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .challenge(challenge_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .response(response_a), .rsp_unstable(rsp_unstable_a), .busy(busy_a)
  );

  xpapuf_tmv #(.RW(RW_B), .XN(XN_B), .VOTES(V_B), .SETTLE(S_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .challenge(challenge_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .response(response_b), .rsp_unstable(rsp_unstable_b), .busy(busy_b)
  );

  // Cell stub: every cell output is overridden from the current stimulus word.
  for (genvar b = 0; b < RW_A; b++) begin : g_force_a
    always @(stim_gen_a) force dut_a.g_bit[b].u_bit.cell_resp = cells_a[b*XN_A +: XN_A];
  end
  for (genvar b = 0; b < RW_B; b++) begin : g_force_b
    always @(stim_gen_b) force dut_b.g_bit[b].u_bit.cell_resp = cells_b[b*XN_B +: XN_B];
  end

  function automatic void model_votes(input int rw, input int xn, input int votes,
                                      input logic [31:0] s [15],
                                      output logic [63:0] resp, output logic [63:0] unst);
    resp = '0;
    unst = '0;
    for (int b = 0; b < rw; b++) begin
      int cnt;
      cnt = 0;
      for (int e = 0; e < votes; e++) begin
        logic p;
        p = 1'b0;
        for (int c = 0; c < xn; c++) p = p ^ s[e][b*xn + c];
        cnt += int'(p);
      end
      resp[b] = (2 * cnt > votes);
      unst[b] = (cnt > 0) && (cnt < votes);
    end
  endfunction

  // Random cell values whose per-bit XOR equals raw.
  function automatic logic [31:0] make_cells(input logic [63:0] raw, input int rw, input int xn);
    logic [31:0] v;
    v = $urandom();
    for (int b = 0; b < rw; b++) begin
      logic p;
      p = 1'b0;
      for (int c = 0; c < xn; c++) p = p ^ v[b*xn + c];
      if (p != raw[b]) v[b*xn] = ~v[b*xn];
    end
    return v;
  endfunction

  task automatic run_a(input logic [15:0] chal, output int lat, output int rises, output int highs);
    int  cycle;
    logic prev;
    @(posedge clk); #1;
    challenge_a = chal;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    cycle = 0; prev = 1'b0; rises = 0; highs = 0;
    cells_a = seq_a[0]; stim_gen_a++;
    while (rsp_valid_a !== 1'b1 && cycle < 400) begin
      if (dut_a.pulse === 1'b1) begin
        highs++;
        if (!prev) rises++;
      end
      prev = dut_a.pulse;
      @(posedge clk); #1;
      cycle++;
      if (cycle % EVAL_A == 0 && cycle / EVAL_A < V_A) begin
        cells_a = seq_a[cycle / EVAL_A]; stim_gen_a++;
      end
    end
    lat = (rsp_valid_a === 1'b1) ? cycle : -1;
  endtask

  task automatic run_b(input logic [15:0] chal, output int lat, output int rises, output int highs);
    int  cycle;
    logic prev;
    @(posedge clk); #1;
    challenge_b = chal;
    req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    cycle = 0; prev = 1'b0; rises = 0; highs = 0;
    cells_b = seq_b[0]; stim_gen_b++;
    while (rsp_valid_b !== 1'b1 && cycle < 400) begin
      if (dut_b.pulse === 1'b1) begin
        highs++;
        if (!prev) rises++;
      end
      prev = dut_b.pulse;
      @(posedge clk); #1;
      cycle++;
      if (cycle % EVAL_B == 0 && cycle / EVAL_B < V_B) begin
        cells_b = seq_b[cycle / EVAL_B]; stim_gen_b++;
      end
    end
    lat = (rsp_valid_b === 1'b1) ? cycle : -1;
  endtask

  task automatic consume_a();
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0;
  endtask

  task automatic consume_b();
    rsp_ready_b = 1'b1;
    @(posedge clk); #1;
    rsp_ready_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid_a = 1'b0; rsp_ready_a = 1'b0; challenge_a = '0;
    req_valid_b = 1'b0; rsp_ready_b = 1'b0; challenge_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (req_ready_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready_a); end
    checks++; if (dut_a.pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulse: got %b expected 0", dut_a.pulse); end
    checks++; if (rsp_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (response_a !== 16'h0000) begin failures++; $display("[TB] FAIL reset_response: got %h expected 0000", response_a); end
    checks++; if (rsp_unstable_a !== 16'h0000) begin failures++; $display("[TB] FAIL reset_unstable: got %h expected 0000", rsp_unstable_a); end
    checks++; if (req_ready_b !== 1'b1 || response_b !== 8'h00) begin failures++; $display("[TB] FAIL reset_b: ready %b resp %h expected 1 00", req_ready_b, response_b); end
  endtask

  task automatic test_stable();
    int lat, rises, highs;
    for (int e = 0; e < V_A; e++) seq_a[e] = make_cells(64'hA5C3, RW_A, XN_A);
    run_a(16'($urandom()), lat, rises, highs);
    checks++; if (lat !== 25) begin failures++; $display("[TB] FAIL stable_latency: got %0d expected 25", lat); end
    checks++; if (response_a !== 16'hA5C3) begin failures++; $display("[TB] FAIL stable_response: got %h expected a5c3", response_a); end
    checks++; if (rsp_unstable_a !== 16'h0000) begin failures++; $display("[TB] FAIL stable_unstable: got %h expected 0000", rsp_unstable_a); end
    checks++; if (rises !== 5) begin failures++; $display("[TB] FAIL stable_pulse_rises: got %0d expected 5", rises); end
    checks++; if (highs !== 15) begin failures++; $display("[TB] FAIL stable_pulse_high: got %0d expected 15", highs); end
    checks++; if (busy_a !== 1'b0 || req_ready_a !== 1'b0) begin failures++; $display("[TB] FAIL stable_done_flags: busy %b ready %b expected 0 0", busy_a, req_ready_a); end
    consume_a();
    checks++; if (req_ready_a !== 1'b1 || rsp_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL stable_handshake: ready %b valid %b expected 1 0", req_ready_a, rsp_valid_a); end
  endtask

  task automatic test_noisy();
    int lat, rises, highs;
    logic [4:0] pat1, pat2;
    pat1 = 5'b01011;
    pat2 = 5'b00100;
    for (int e = 0; e < V_A; e++) seq_a[e] = make_cells({63'b0, pat1[e]}, RW_A, XN_A);
    run_a(16'($urandom()), lat, rises, highs);
    checks++; if (response_a !== 16'h0001) begin failures++; $display("[TB] FAIL noisy1_response: got %h expected 0001", response_a); end
    checks++; if (rsp_unstable_a !== 16'h0001) begin failures++; $display("[TB] FAIL noisy1_unstable: got %h expected 0001", rsp_unstable_a); end
    consume_a();
    for (int e = 0; e < V_A; e++) seq_a[e] = make_cells({63'b0, pat2[e]}, RW_A, XN_A);
    run_a(16'($urandom()), lat, rises, highs);
    checks++; if (response_a !== 16'h0000) begin failures++; $display("[TB] FAIL noisy2_response: got %h expected 0000", response_a); end
    checks++; if (rsp_unstable_a !== 16'h0001) begin failures++; $display("[TB] FAIL noisy2_unstable: got %h expected 0001", rsp_unstable_a); end
    consume_a();
  endtask

  task automatic test_random();
    int lat, rises, highs;
    logic [63:0] exp_r, exp_u;
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < V_A; e++) seq_a[e] = $urandom();
      model_votes(RW_A, XN_A, V_A, seq_a, exp_r, exp_u);
      run_a(16'($urandom()), lat, rises, highs);
      checks++; if (lat !== V_A * EVAL_A) begin failures++; $display("[TB] FAIL random_latency: round %0d got %0d expected %0d", r, lat, V_A * EVAL_A); end
      checks++; if (response_a !== exp_r[RW_A-1:0]) begin failures++; $display("[TB] FAIL random_response: round %0d got %h expected %h", r, response_a, exp_r[RW_A-1:0]); end
      checks++; if (rsp_unstable_a !== exp_u[RW_A-1:0]) begin failures++; $display("[TB] FAIL random_unstable: round %0d got %h expected %h", r, rsp_unstable_a, exp_u[RW_A-1:0]); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++; if (response_a !== exp_r[RW_A-1:0] || rsp_valid_a !== 1'b1) begin failures++; $display("[TB] FAIL random_hold: round %0d got %h valid %b expected %h 1", r, response_a, rsp_valid_a, exp_r[RW_A-1:0]); end
      consume_a();
    end
  endtask

  task automatic test_backpressure();
    int lat, rises, highs, waited;
    logic [15:0] raw, chal1, chal2;
    raw   = 16'($urandom());
    chal1 = 16'($urandom());
    chal2 = ~chal1;
    for (int e = 0; e < V_A; e++) seq_a[e] = make_cells({48'b0, raw}, RW_A, XN_A);
    run_a(chal1, lat, rises, highs);
    checks++; if (response_a !== raw) begin failures++; $display("[TB] FAIL bp_response: got %h expected %h", response_a, raw); end
    req_valid_a = 1'b1;
    challenge_a = chal2;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++; if (response_a !== raw || req_ready_a !== 1'b0 || rsp_valid_a !== 1'b1) begin
        failures++; $display("[TB] FAIL bp_hold: cycle %0d resp %h ready %b valid %b expected %h 0 1", k, response_a, req_ready_a, rsp_valid_a, raw);
      end
    end
    checks++; if (dut_a.chal_q !== chal1) begin failures++; $display("[TB] FAIL bp_no_latch: got %h expected %h", dut_a.chal_q, chal1); end
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0;
    checks++; if (req_ready_a !== 1'b1 || busy_a !== 1'b0 || dut_a.chal_q !== chal1) begin
      failures++; $display("[TB] FAIL bp_same_cycle: ready %b busy %b chal %h expected 1 0 %h", req_ready_a, busy_a, dut_a.chal_q, chal1);
    end
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    checks++; if (busy_a !== 1'b1 || dut_a.chal_q !== chal2) begin
      failures++; $display("[TB] FAIL bp_accept_next: busy %b chal %h expected 1 %h", busy_a, dut_a.chal_q, chal2);
    end
    waited = 0;
    while (rsp_valid_a !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++; if (rsp_valid_a !== 1'b1) begin failures++; $display("[TB] FAIL bp_drain: got valid %b expected 1", rsp_valid_a); end
    consume_a();
  endtask

  task automatic test_reset_mid();
    int lat, rises, highs;
    @(posedge clk); #1;
    challenge_a = 16'($urandom());
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    cells_a = make_cells(64'hFF00, RW_A, XN_A); stim_gen_a++;
    repeat (2 * EVAL_A + 2) @(posedge clk);
    #1;
    checks++; if (dut_a.pulse !== 1'b1 || busy_a !== 1'b1) begin failures++; $display("[TB] FAIL mid_in_fire: pulse %b busy %b expected 1 1", dut_a.pulse, busy_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy_a !== 1'b0 || req_ready_a !== 1'b1 || dut_a.pulse !== 1'b0 || rsp_valid_a !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_reset_idle: busy %b ready %b pulse %b valid %b expected 0 1 0 0", busy_a, req_ready_a, dut_a.pulse, rsp_valid_a);
    end
    for (int e = 0; e < V_A; e++) seq_a[e] = make_cells(64'h00FF, RW_A, XN_A);
    run_a(16'($urandom()), lat, rises, highs);
    checks++; if (lat !== 25) begin failures++; $display("[TB] FAIL mid_after_latency: got %0d expected 25", lat); end
    checks++; if (response_a !== 16'h00FF) begin failures++; $display("[TB] FAIL mid_after_response: got %h expected 00ff", response_a); end
    checks++; if (rsp_unstable_a !== 16'h0000) begin failures++; $display("[TB] FAIL mid_after_unstable: got %h expected 0000", rsp_unstable_a); end
    consume_a();
  endtask

  task automatic test_xn4();
    int lat, rises, highs;
    logic [63:0] exp_r, exp_u;
    for (int e = 0; e < V_B; e++) seq_b[e] = make_cells(64'h3C, RW_B, XN_B);
    run_b(16'($urandom()), lat, rises, highs);
    checks++; if (lat !== 18) begin failures++; $display("[TB] FAIL xn4_latency: got %0d expected 18", lat); end
    checks++; if (response_b !== 8'h3C) begin failures++; $display("[TB] FAIL xn4_response: got %h expected 3c", response_b); end
    checks++; if (rsp_unstable_b !== 8'h00) begin failures++; $display("[TB] FAIL xn4_unstable: got %h expected 00", rsp_unstable_b); end
    checks++; if (rises !== 3 || highs !== 12) begin failures++; $display("[TB] FAIL xn4_pulse: rises %0d high %0d expected 3 12", rises, highs); end
    consume_b();
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < V_B; e++) seq_b[e] = $urandom();
      model_votes(RW_B, XN_B, V_B, seq_b, exp_r, exp_u);
      run_b(16'($urandom()), lat, rises, highs);
      checks++; if (response_b !== exp_r[RW_B-1:0] || rsp_unstable_b !== exp_u[RW_B-1:0]) begin
        failures++; $display("[TB] FAIL xn4_random: round %0d got %h/%h expected %h/%h", r, response_b, rsp_unstable_b, exp_r[RW_B-1:0], exp_u[RW_B-1:0]);
      end
      consume_b();
    end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_noisy();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_xn4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xpapuf_tmv.md
# xpapuf_tmv

Parametrised XOR arbiter-PUF evaluator with an on-chip sequencer and temporal majority voting (TMV). It accepts a challenge over a valid/ready handshake and drives the shared `pulse` into RW×XN `papuf_ff1` cells. Each evaluation XORs XN cells per response bit, repeats VOTES times, and majority-votes each bit. It returns the voted response plus a per-bit instability flag. It replaces free-running, unclocked 2-bank XOR arrays in the key-generation path.

## Interface
- `RW`, 16: response width (1..64).
- `XN`, 2: XOR order, cells per response bit (1..4).
- `VOTES`, 5: evaluations per request (odd, 1..15).
- `SETTLE`, 3: cycles `pulse` held high before sampling (≥3, ≤255).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: challenge request.
- `req_ready` out 1: block idle, can accept.
- `challenge` in 16: challenge, matches the `papuf_ff1` cell width.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts response.
- `response` out RW: majority-voted response.
- `rsp_unstable` out RW: bit i = 1 if its votes were not unanimous.
- `busy` out 1: evaluation in progress (state ≠ IDLE/DONE).

## Operation
- FSM states and transitions:
  - IDLE → ARM on `req_valid && req_ready`. The challenge is latched into `chal_q` on that edge.
  - ARM → FIRE after 1 cycle. `pulse` = 0, resetting the arbiters.
  - FIRE → SAMPLE after SETTLE cycles. `pulse` = 1.
  - SAMPLE → ARM if `vote_cnt < VOTES`, else → DONE. `pulse` = 0.
  - DONE → IDLE on `rsp_valid && rsp_ready`.
- `req_ready` = 1 only in IDLE. `req_valid` in any other state is ignored, with no queueing.
- Raw path: `raw[i]` = XOR of the XN cell outputs for bit i. All cells see `chal_q` and `pulse`.
- `raw` passes through a free-running 2-flop synchroniser.
- In SAMPLE the synchroniser output is read and `ones[i]` increments when it is 1. `vote_cnt` increments.
- Counter widths: `ones[i]` and `vote_cnt` are $clog2(VOTES+1) bits. They cannot overflow, since the maximum count is VOTES.
- On entry to DONE:
  - `response[i]` = `ones[i] > VOTES/2` (integer division).
  - `rsp_unstable[i]` = `ones[i] != 0 && ones[i] != VOTES`.
  - Both are registered and held stable until the handshake completes.
- `ones` and `vote_cnt` clear on the IDLE→ARM transition.
- VOTES = 1: a single evaluation. `rsp_unstable` is always 0.
- A simultaneous `rsp_ready` and new `req_valid` in DONE: the response is consumed, and the new request is accepted only in the next cycle (in IDLE).

## Timing
- Reset values:
  - state IDLE, `pulse` = 0, `req_ready` = 1.
  - `rsp_valid` = 0, `busy` = 0.
  - `response` = 0, `rsp_unstable` = 0.
  - counters 0, `chal_q` = 0.
- Reset mid-evaluation: IDLE on the next edge, `pulse` = 0, and the partial votes are discarded.
- One evaluation = SETTLE+2 cycles (ARM 1 + FIRE SETTLE + SAMPLE 1).
- `rsp_valid` rises exactly VOTES×(SETTLE+2) cycles after the accepting edge. With the defaults that is 25 cycles.
- `pulse` is driven from a register with no combinational path from the inputs.
- The sample point lags the rising edge of `pulse` by SETTLE cycles, which covers the 2-flop synchroniser latency.

## Structure
- Package `papuf_pkg`:
  - FSM state enum (IDLE, ARM, FIRE, SAMPLE, DONE).
  - `PAPUF_CW` = 16.
  - Parameter-check function: VOTES odd, SETTLE ≥3.
- Sub-module `papuf_xor_bit`: XN `papuf_ff1` instances plus the XOR reduction, producing one raw bit. It is generated RW times.
- Top: FSM, synchroniser, vote counters, output registers.

## Test plan
Simulation uses a behavioural `papuf_ff1` stub whose outputs are forced per evaluation.
- Reset: `rst` held 2 cycles → `req_ready` = 1, `pulse` = 0, `rsp_valid` = 0, `response` = 16'h0000.
- Stable case: defaults, stub raw = 16'hA5C3 on every evaluation → `response` = 16'hA5C3, `rsp_unstable` = 0, `rsp_valid` 25 cycles after accept. `pulse` rises 5 times, each time high for 3 cycles.
- Noisy bit: bit 0 raw sequence 1,1,0,1,0, other bits 0 → `response` = 16'h0001, `rsp_unstable` = 16'h0001. With sequence 0,0,1,0,0 → `response` bit 0 = 0, `rsp_unstable` bit 0 = 1.
- Backpressure: `rsp_ready` = 0 for 10 cycles with `req_valid` = 1 and a new challenge → `response` held, `req_ready` = 0, second challenge not latched. Accepted only after the handshake plus 1 cycle.
- Reset mid-run: `rst` in the third evaluation → IDLE next cycle, `pulse` = 0. A following request with stub 16'h00FF → `response` = 16'h00FF, with no residual votes.
- Build XN = 4, RW = 8, VOTES = 3, SETTLE = 4: raw forced per cell so the XOR = 8'h3C → `response` = 8'h3C, latency 18 cycles.
